// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode definitions and response-slot state encoding for alu_arbiter.
// Branch opcodes return in1 - in2 as data alongside their predicate.
package alu_arbiter_pkg;

    localparam int unsigned DataW  = 32;
    localparam int unsigned NumReq = 2;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9,
        AluBeq  = 4'd10,
        AluBne  = 4'd11,
        AluBlt  = 4'd12,
        AluBge  = 4'd13,
        AluBltu = 4'd14,
        AluBgeu = 4'd15
    } alu_op_e;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: arithmetic/logic result plus branch predicate.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  alu_op_e          op_i,
    input  logic [DataW-1:0] in1_i,
    input  logic [DataW-1:0] in2_i,
    output logic [DataW-1:0] result_o,
    output logic             branch_o
);

    logic [DataW-1:0] diff;
    logic             lt_s;
    logic             lt_u;

    assign diff = in1_i - in2_i;
    assign lt_s = $signed(in1_i) < $signed(in2_i);
    assign lt_u = in1_i < in2_i;

    always_comb begin
        result_o = diff;
        branch_o = 1'b0;
        unique case (op_i)
            AluAdd:  result_o = in1_i + in2_i;
            AluSub:  result_o = diff;
            AluAnd:  result_o = in1_i & in2_i;
            AluOr:   result_o = in1_i | in2_i;
            AluXor:  result_o = in1_i ^ in2_i;
            AluSll:  result_o = in1_i << in2_i[4:0];
            AluSrl:  result_o = in1_i >> in2_i[4:0];
            AluSra:  result_o = $unsigned($signed(in1_i) >>> in2_i[4:0]);
            AluSlt:  result_o = {{(DataW-1){1'b0}}, lt_s};
            AluSltu: result_o = {{(DataW-1){1'b0}}, lt_u};
            AluBeq:  branch_o = (in1_i == in2_i);
            AluBne:  branch_o = (in1_i != in2_i);
            AluBlt:  branch_o = lt_s;
            AluBge:  branch_o = ~lt_s;
            AluBltu: branch_o = lt_u;
            AluBgeu: branch_o = ~lt_u;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; each owns a single-entry response slot.
// FAIR=1 alternates on contention, FAIR=0 always favours requester 0.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [DataW-1:0] req0_in1,
    input  logic [DataW-1:0] req0_in2,
    input  logic [DataW-1:0] req1_in1,
    input  logic [DataW-1:0] req1_in2,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [DataW-1:0] rsp0_data,
    output logic [DataW-1:0] rsp1_data,
    output logic             rsp0_branch,
    output logic             rsp1_branch
);

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       elig;
    logic [1:0]       grant;
    slot_e            slot_q [NumReq];
    slot_e            slot_d [NumReq];
    logic [DataW-1:0] data_q [NumReq];
    logic [1:0]       branch_q;
    // 1 = requester 1 was granted most recently
    logic             last_q;
    logic             last_d;

    logic [DataW-1:0] alu_in1;
    logic [DataW-1:0] alu_in2;
    logic [3:0]       alu_op;
    logic [DataW-1:0] alu_result;
    logic             alu_branch;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            elig[k] = req_valid[k] & ((slot_q[k] == SlotEmpty) | rsp_ready[k]);
        end
        grant = elig;
        if (elig == 2'b11) begin
            grant = (FAIR && !last_q) ? 2'b10 : 2'b01;
        end
        last_d = last_q;
        if (grant != 2'b00) begin
            last_d = grant[1];
        end
    end

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            slot_d[k] = slot_q[k];
            unique case (slot_q[k])
                SlotEmpty: if (grant[k]) slot_d[k] = SlotFull;
                SlotFull:  if (rsp_ready[k] && !grant[k]) slot_d[k] = SlotEmpty;
                default:   slot_d[k] = SlotEmpty;
            endcase
        end
    end

    // Idle cycles leave the ALU looking at requester 0's operands.
    assign alu_in1 = grant[1] ? req1_in1 : req0_in1;
    assign alu_in2 = grant[1] ? req1_in2 : req0_in2;
    assign alu_op  = grant[1] ? req1_op  : req0_op;

    alu_arbiter_alu u_alu (
        .op_i     (alu_op_e'(alu_op)),
        .in1_i    (alu_in1),
        .in2_i    (alu_in2),
        .result_o (alu_result),
        .branch_o (alu_branch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NumReq; k++) begin
                slot_q[k] <= SlotEmpty;
                data_q[k] <= '0;
            end
            branch_q <= '0;
            last_q   <= 1'b1;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                slot_q[k] <= slot_d[k];
                if (grant[k]) begin
                    data_q[k]   <= alu_result;
                    branch_q[k] <= alu_branch;
                end
            end
            last_q <= last_d;
        end
    end

    // Reset gating keeps ready low even while requests are presented during reset.
    assign req0_ready  = grant[0] & rst_n;
    assign req1_ready  = grant[1] & rst_n;
    assign rsp0_valid  = (slot_q[0] == SlotFull);
    assign rsp1_valid  = (slot_q[1] == SlotFull);
    assign rsp0_data   = data_q[0];
    assign rsp1_data   = data_q[1];
    assign rsp0_branch = branch_q[0];
    assign rsp1_branch = branch_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic
// against a behavioural model, for both FAIR=1 and FAIR=0 instances.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic        br;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fair_mode = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] in1 [2];
    logic [31:0] in2 [2];
    logic [3:0]  op  [2];

    logic [1:0]  f_req_ready, f_rsp_valid, f_rsp_branch;
    logic [31:0] f_rsp_data [2];
    logic [1:0]  x_req_ready, x_rsp_valid, x_rsp_branch;
    logic [31:0] x_rsp_data [2];

    logic [1:0]  req_ready, rsp_valid, rsp_branch;
    logic [31:0] rsp_data [2];

    int   n_checks = 0;
    int   n_fail = 0;
    rsp_t exp_q [2][$];
    rsp_t held_m [2];
    bit   full_m [2];
    bit   last_m;
    int   glog [$];
    int   winner;
    logic [1:0] m_elig, m_gexp;

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR(1'b1)) u_fair (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req1_valid(req_valid[1]),
        .req0_ready(f_req_ready[0]), .req1_ready(f_req_ready[1]),
        .req0_in1(in1[0]), .req0_in2(in2[0]), .req1_in1(in1[1]), .req1_in2(in2[1]),
        .req0_op(op[0]), .req1_op(op[1]),
        .rsp0_valid(f_rsp_valid[0]), .rsp1_valid(f_rsp_valid[1]),
        .rsp0_ready(rsp_ready[0]), .rsp1_ready(rsp_ready[1]),
        .rsp0_data(f_rsp_data[0]), .rsp1_data(f_rsp_data[1]),
        .rsp0_branch(f_rsp_branch[0]), .rsp1_branch(f_rsp_branch[1])
    );

    alu_arbiter #(.FAIR(1'b0)) u_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req1_valid(req_valid[1]),
        .req0_ready(x_req_ready[0]), .req1_ready(x_req_ready[1]),
        .req0_in1(in1[0]), .req0_in2(in2[0]), .req1_in1(in1[1]), .req1_in2(in2[1]),
        .req0_op(op[0]), .req1_op(op[1]),
        .rsp0_valid(x_rsp_valid[0]), .rsp1_valid(x_rsp_valid[1]),
        .rsp0_ready(rsp_ready[0]), .rsp1_ready(rsp_ready[1]),
        .rsp0_data(x_rsp_data[0]), .rsp1_data(x_rsp_data[1]),
        .rsp0_branch(x_rsp_branch[0]), .rsp1_branch(x_rsp_branch[1])
    );

    always_comb begin
        req_ready   = fair_mode ? f_req_ready  : x_req_ready;
        rsp_valid   = fair_mode ? f_rsp_valid  : x_rsp_valid;
        rsp_branch  = fair_mode ? f_rsp_branch : x_rsp_branch;
        rsp_data[0] = fair_mode ? f_rsp_data[0] : x_rsp_data[0];
        rsp_data[1] = fair_mode ? f_rsp_data[1] : x_rsp_data[1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic rsp_t ref_alu(input logic [3:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        rsp_t r;
        int   sh;
        sh = int'(b % 32);
        r.br = 1'b0;
        r.data = a - b;
        case (o)
            4'd0: r.data = a + b;
            4'd2: r.data = a & b;
            4'd3: r.data = a | b;
            4'd4: r.data = a ^ b;
            4'd5: r.data = a << sh;
            4'd6: r.data = a >> sh;
            4'd7: r.data = 32'($signed(a) >>> sh);
            4'd8: r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r.data = (a < b) ? 32'd1 : 32'd0;
            4'd10: r.br = (a == b);
            4'd11: r.br = (a != b);
            4'd12: r.br = ($signed(a) < $signed(b));
            4'd13: r.br = ($signed(a) >= $signed(b));
            4'd14: r.br = (a < b);
            4'd15: r.br = (a >= b);
            default: ;
        endcase
        return r;
    endfunction

    // Monitor and scoreboard: model advances once per cycle at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("ready_in_reset", 64'(req_ready), 64'd0);
            check("valid_in_reset", 64'(rsp_valid), 64'd0);
            for (int k = 0; k < 2; k++) begin
                exp_q[k].delete();
                full_m[k] = 1'b0;
                held_m[k] = '0;
            end
            last_m = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_elig[k] = req_valid[k] && (!full_m[k] || rsp_ready[k]);
            end
            winner = -1;
            if (m_elig == 2'b11) winner = fair_mode ? (last_m ? 0 : 1) : 0;
            else if (m_elig[0]) winner = 0;
            else if (m_elig[1]) winner = 1;
            m_gexp = '0;
            if (winner >= 0) m_gexp[winner] = 1'b1;
            check("grant", 64'(req_ready), 64'(m_gexp));
            if (req_ready[0]) glog.push_back(0);
            else if (req_ready[1]) glog.push_back(1);

            for (int k = 0; k < 2; k++) begin
                check("rsp_valid", 64'(rsp_valid[k]), 64'(full_m[k]));
                if (full_m[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("scoreboard_empty", 64'(exp_q[k].size()), 64'd1);
                    end else begin
                        check("rsp_data", 64'({rsp_branch[k], rsp_data[k]}), 64'(exp_q[k][0]));
                        if (rsp_ready[k]) void'(exp_q[k].pop_front());
                    end
                end else begin
                    check("rsp_hold_empty", 64'({rsp_branch[k], rsp_data[k]}), 64'(held_m[k]));
                end
            end

            if (winner >= 0) begin
                held_m[winner] = ref_alu(op[winner], in1[winner], in2[winner]);
                exp_q[winner].push_back(held_m[winner]);
                last_m = (winner == 1);
            end
            for (int k = 0; k < 2; k++) begin
                full_m[k] = (winner == k) || (full_m[k] && !rsp_ready[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic mode);
        step();
        rst_n = 1'b0;
        fair_mode = mode;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int k, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b);
        op[k]  = o;
        in1[k] = a;
        in2[k] = b;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = ($urandom_range(0, 3) != 0);
                rsp_ready[k] = ($urandom_range(0, 3) != 0);
                op[k]  = 4'($urandom_range(0, 15));
                in1[k] = $urandom;
                in2[k] = ($urandom_range(0, 3) == 0) ? in1[k] : $urandom;
            end
            @(negedge clk);
            step();
        end
    endtask

    task automatic both_valid_grants(input logic mode, input int e0, input int e1,
                                     input int e2, input int e3);
        int exp_g [4];
        exp_g = '{e0, e1, e2, e3};
        apply_reset(mode);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        set_req(0, AluAdd, 32'd1, 32'd2);
        set_req(1, AluXor, 32'hF0, 32'h0F);
        glog.delete();
        repeat (4) begin
            @(negedge clk);
            step();
        end
        req_valid = '0;
        check("grant_count", 64'(glog.size()), 64'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            check("grant_order", 64'(glog[i]), 64'(exp_g[i]));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) set_req(k, AluAdd, 32'd0, 32'd0);

        // Single ADD: ready this cycle, result 12 the next.
        apply_reset(1'b1);
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        set_req(0, AluAdd, 32'd5, 32'd7);
        @(negedge clk);
        check("add_ready", 64'(req_ready), 64'b01);
        step();
        req_valid = '0;
        @(negedge clk);
        check("add_valid", 64'(rsp_valid[0]), 64'd1);
        check("add_data", 64'(rsp_data[0]), 64'd12);

        // Branch predicates.
        step();
        req_valid = 2'b01;
        set_req(0, AluBeq, 32'd9, 32'd9);
        @(negedge clk);
        step();
        set_req(0, AluBne, 32'd9, 32'd9);
        @(negedge clk);
        check("beq_branch", 64'(rsp_branch[0]), 64'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("bne_branch", 64'(rsp_branch[0]), 64'd0);

        both_valid_grants(1'b1, 0, 1, 0, 1);
        both_valid_grants(1'b0, 0, 0, 0, 0);
        run_random(300);

        // Full slot 1 blocks a pending SUB until drained.
        apply_reset(1'b1);
        req_valid = 2'b10;
        set_req(1, AluAdd, 32'd1, 32'd2);
        @(negedge clk);
        check("fill_slot1", 64'(req_ready), 64'b10);
        step();
        set_req(1, AluSub, 32'd3, 32'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sub_blocked", 64'(req_ready[1]), 64'd0);
            step();
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("sub_on_drain", 64'(req_ready[1]), 64'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("sub_valid", 64'(rsp_valid[1]), 64'd1);
        check("sub_data", 64'(rsp_data[1]), 64'hFFFF_FFF9);

        // Reset in the middle of a granting cycle.
        apply_reset(1'b1);
        req_valid = 2'b11;
        set_req(0, AluOr, 32'h10, 32'h01);
        set_req(1, AluAnd, 32'hFF, 32'h0F);
        repeat (2) begin
            @(negedge clk);
            step();
        end
        rsp_ready = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_data0", 64'(rsp_data[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_after_rst", 64'(req_ready), 64'b01);
        step();
        req_valid = '0;

        run_random(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
